discrete_range_sampler: RTL and testbench

Parametrised successor of the fixed four-variable discrete range randomizer. On request it picks one of the programmed discrete ranges of a selected integer variable and returns its start/end bounds. Selection is uniform over the variable's populated slots, using rejection sampling on an internal LFSR. The range table is run-time programmable instead of hard-wired. The block sits between the MCMC proposal controller and the integer-variable update path.

---
 rtl/discrete_sampler_pkg.sv | 33 +++
 rtl/lfsr16.sv | 32 +++
 rtl/discrete_range_sampler.sv | 235 +++++++++++++++++++++++
 tb/tb_discrete_range_sampler.sv | 369 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/discrete_sampler_pkg.sv
// Shared definitions for the discrete range sampler.
// Holds the controller state encoding, the LFSR feedback mask and zero-seed
// substitute, the single-step Galois LFSR function and the derived-width
// helpers used to size index and counter ports.
package discrete_sampler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRAW   = 2'd1,
    ST_LOOKUP = 2'd2,
    ST_DONE   = 2'd3
  } sampler_state_t;

  // x^16 + x^14 + x^13 + x^11 + 1, right-shifting Galois form
  localparam logic [15:0] LFSR_MASK      = 16'hB400;
  // An all-zero LFSR never leaves zero, so a zero seed is replaced
  localparam logic [15:0] LFSR_ZERO_SEED = 16'hACE1;

  // Index width for n entries, never narrower than one bit
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Width able to hold the values 0..n inclusive
  function automatic int count_width(input int n);
    return (n > 0) ? $clog2(n + 1) : 1;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return s[0] ? ((s >> 1) ^ LFSR_MASK) : (s >> 1);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR with synchronous seed load and step enable.
// Ports:
//   in_clock      clock, rising edge
//   in_load       load seed (zero seed replaced by the fixed substitute)
//   in_seed       seed value
//   in_enable     advance one step
//   out_candidate low CAND_W bits of the current state
module lfsr16
  import discrete_sampler_pkg::*;
#(
  parameter int CAND_W = 2
) (
  input  logic              in_clock,
  input  logic              in_load,
  input  logic [15:0]       in_seed,
  input  logic              in_enable,
  output logic [CAND_W-1:0] out_candidate
);

  logic [15:0] r_state;

  always_ff @(posedge in_clock) begin
    if (in_load) begin
      r_state <= (in_seed == 16'h0000) ? LFSR_ZERO_SEED : in_seed;
    end else if (in_enable) begin
      r_state <= lfsr_step(r_state);
    end
  end

  assign out_candidate = r_state[CAND_W-1:0];

endmodule

// File: rtl/discrete_range_sampler.sv
// Discrete range sampler: on request, picks one populated range slot of the
// selected variable uniformly (rejection sampling on an LFSR, with a modulo
// fallback after MAX_TRIES rejections) and returns its start/end bounds.
// The range table and per-variable slot counts are programmed at run time.
// Ports:
//   in_clock / in_reset           clock, synchronous active-high reset
//   in_seed                       LFSR seed, loaded while in reset
//   in_cfg_write, in_cfg_variable, in_cfg_slot, in_cfg_start, in_cfg_end
//                                 write one range slot (IDLE only)
//   in_cfg_size_write, in_cfg_size
//                                 write slot count of in_cfg_variable (IDLE only)
//   in_request, in_variable_index start a draw for a variable
//   out_ready                     block idle, request will be accepted
//   out_valid                     one-cycle result strobe
//   out_start/out_end/out_equal/out_slot
//                                 chosen range, held until the next result
//   out_fallback / out_error      result from modulo fallback / empty variable
module discrete_range_sampler
  import discrete_sampler_pkg::*;
#(
  parameter  int NUM_VARIABLES = 4,
  parameter  int MAX_VALUES    = 4,
  parameter  int VALUE_WIDTH   = 8,
  parameter  int MAX_TRIES     = 8,
  localparam int VAR_IDX_W     = idx_width(NUM_VARIABLES),
  localparam int VAL_IDX_W     = idx_width(MAX_VALUES)
) (
  input  logic                   in_clock,
  input  logic                   in_reset,
  input  logic [15:0]            in_seed,
  input  logic                   in_cfg_write,
  input  logic [VAR_IDX_W-1:0]   in_cfg_variable,
  input  logic [VAL_IDX_W-1:0]   in_cfg_slot,
  input  logic [VALUE_WIDTH-1:0] in_cfg_start,
  input  logic [VALUE_WIDTH-1:0] in_cfg_end,
  input  logic                   in_cfg_size_write,
  input  logic [VAL_IDX_W:0]     in_cfg_size,
  input  logic                   in_request,
  input  logic [VAR_IDX_W-1:0]   in_variable_index,
  output logic                   out_ready,
  output logic                   out_valid,
  output logic [VALUE_WIDTH-1:0] out_start,
  output logic [VALUE_WIDTH-1:0] out_end,
  output logic                   out_equal,
  output logic [VAL_IDX_W-1:0]   out_slot,
  output logic                   out_fallback,
  output logic                   out_error
);

  localparam int TRY_W  = count_width(MAX_TRIES);
  localparam int SIZE_W = VAL_IDX_W + 1;

  sampler_state_t r_state;
  sampler_state_t w_next_state;

  // Draw context
  logic [VAR_IDX_W-1:0]   r_var;
  logic [TRY_W-1:0]       r_try;
  logic [VAL_IDX_W-1:0]   r_slot;
  logic                   r_fallback_pend;
  logic                   r_error_pend;

  // Range table and populated-slot counts
  logic [VALUE_WIDTH-1:0] r_tbl_start [NUM_VARIABLES][MAX_VALUES];
  logic [VALUE_WIDTH-1:0] r_tbl_end   [NUM_VARIABLES][MAX_VALUES];
  logic [SIZE_W-1:0]      r_size      [NUM_VARIABLES];

  // Result registers
  logic                   r_out_valid;
  logic [VALUE_WIDTH-1:0] r_out_start;
  logic [VALUE_WIDTH-1:0] r_out_end;
  logic                   r_out_equal;
  logic [VAL_IDX_W-1:0]   r_out_slot;
  logic                   r_out_fallback;
  logic                   r_out_error;

  logic [VAL_IDX_W-1:0]   w_cand;
  logic                   w_lfsr_en;
  logic                   w_idle;
  logic                   w_var_ok;
  logic                   w_cfg_var_ok;
  logic                   w_cfg_slot_ok;
  logic [SIZE_W-1:0]      w_size;
  logic [SIZE_W-1:0]      w_cfg_size_sat;
  logic                   w_cand_ok;
  logic                   w_last_try;
  logic [VAL_IDX_W-1:0]   w_fold;

  lfsr16 #(
    .CAND_W (VAL_IDX_W)
  ) u_lfsr (
    .in_clock      (in_clock),
    .in_load       (in_reset),
    .in_seed       (in_seed),
    .in_enable     (w_lfsr_en),
    .out_candidate (w_cand)
  );

  // Guard indices in case the variable/slot counts are not powers of two
  assign w_var_ok      = (int'(r_var) < NUM_VARIABLES);
  assign w_cfg_var_ok  = (int'(in_cfg_variable) < NUM_VARIABLES);
  assign w_cfg_slot_ok = (int'(in_cfg_slot) < MAX_VALUES);

  assign w_size         = w_var_ok ? r_size[r_var] : '0;
  assign w_cfg_size_sat = (in_cfg_size > SIZE_W'(MAX_VALUES)) ? SIZE_W'(MAX_VALUES)
                                                              : in_cfg_size;

  assign w_cand_ok  = ({1'b0, w_cand} < w_size);
  // This rejection is the one that brings the try count up to MAX_TRIES
  assign w_last_try = (r_try == TRY_W'(MAX_TRIES - 1));
  // Fallback slot; only consumed when the size is non-zero
  assign w_fold     = (w_size == '0) ? '0 : VAL_IDX_W'({1'b0, w_cand} % w_size);

  // State register
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (in_request) begin
          w_next_state = ST_DRAW;
        end
      end
      ST_DRAW: begin
        if (w_size == '0) begin
          w_next_state = ST_DONE;
        end else if (w_cand_ok || w_last_try) begin
          w_next_state = ST_LOOKUP;
        end
      end
      ST_LOOKUP: w_next_state = ST_DONE;
      ST_DONE:   w_next_state = ST_IDLE;
      default:   w_next_state = ST_IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    w_idle    = (r_state == ST_IDLE);
    w_lfsr_en = (r_state == ST_DRAW);
  end

  // Table, draw context and result registers
  always_ff @(posedge in_clock) begin
    if (in_reset) begin
      r_var           <= '0;
      r_try           <= '0;
      r_slot          <= '0;
      r_fallback_pend <= 1'b0;
      r_error_pend    <= 1'b0;
      r_out_valid     <= 1'b0;
      r_out_start     <= '0;
      r_out_end       <= '0;
      r_out_equal     <= 1'b0;
      r_out_slot      <= '0;
      r_out_fallback  <= 1'b0;
      r_out_error     <= 1'b0;
      for (int v = 0; v < NUM_VARIABLES; v++) begin
        r_size[v] <= '0;
        for (int s = 0; s < MAX_VALUES; s++) begin
          r_tbl_start[v][s] <= '0;
          r_tbl_end[v][s]   <= '0;
        end
      end
    end else begin
      r_out_valid <= 1'b0;

      if (w_idle) begin
        if (in_cfg_write && w_cfg_var_ok && w_cfg_slot_ok) begin
          r_tbl_start[in_cfg_variable][in_cfg_slot] <= in_cfg_start;
          r_tbl_end[in_cfg_variable][in_cfg_slot]   <= in_cfg_end;
        end
        if (in_cfg_size_write && w_cfg_var_ok) begin
          r_size[in_cfg_variable] <= w_cfg_size_sat;
        end
        if (in_request) begin
          r_var           <= in_variable_index;
          r_try           <= '0;
          r_fallback_pend <= 1'b0;
          r_error_pend    <= 1'b0;
        end
      end

      if (r_state == ST_DRAW) begin
        if (w_size == '0) begin
          r_error_pend <= 1'b1;
          r_slot       <= '0;
          r_out_start  <= '0;
          r_out_end    <= '0;
          r_out_equal  <= 1'b1;
          r_out_slot   <= '0;
        end else if (w_cand_ok) begin
          r_slot <= w_cand;
        end else if (w_last_try) begin
          r_slot          <= w_fold;
          r_fallback_pend <= 1'b1;
        end else begin
          r_try <= r_try + 1'b1;
        end
      end

      if ((r_state == ST_LOOKUP) && w_var_ok) begin
        r_out_start <= r_tbl_start[r_var][r_slot];
        r_out_end   <= r_tbl_end[r_var][r_slot];
        r_out_equal <= (r_tbl_start[r_var][r_slot] == r_tbl_end[r_var][r_slot]);
        r_out_slot  <= r_slot;
      end

      // Flags are published together with the strobe so they stay aligned
      if (r_state == ST_DONE) begin
        r_out_valid    <= 1'b1;
        r_out_fallback <= r_fallback_pend;
        r_out_error    <= r_error_pend;
      end
    end
  end

  assign out_ready    = w_idle;
  assign out_valid    = r_out_valid;
  assign out_start    = r_out_start;
  assign out_end      = r_out_end;
  assign out_equal    = r_out_equal;
  assign out_slot     = r_out_slot;
  assign out_fallback = r_out_fallback;
  assign out_error    = r_out_error;

endmodule

// File: tb/tb_discrete_range_sampler.sv
`timescale 1ns/1ps
module tb_discrete_range_sampler;

  localparam int NV  = 4;
  localparam int MV  = 4;
  localparam int VW  = 8;
  localparam int MT  = 8;
  localparam int VIW = 2;
  localparam int SIW = 2;

  logic          in_clock = 1'b0;
  logic          in_reset;
  logic [15:0]   in_seed;
  logic          in_cfg_write;
  logic [VIW-1:0] in_cfg_variable;
  logic [SIW-1:0] in_cfg_slot;
  logic [VW-1:0] in_cfg_start;
  logic [VW-1:0] in_cfg_end;
  logic          in_cfg_size_write;
  logic [SIW:0]  in_cfg_size;
  logic          in_request;
  logic [VIW-1:0] in_variable_index;
  logic          out_ready;
  logic          out_valid;
  logic [VW-1:0] out_start;
  logic [VW-1:0] out_end;
  logic          out_equal;
  logic [SIW-1:0] out_slot;
  logic          out_fallback;
  logic          out_error;

  always #5 in_clock = ~in_clock;

  discrete_range_sampler #(
    .NUM_VARIABLES (NV),
    .MAX_VALUES    (MV),
    .VALUE_WIDTH   (VW),
    .MAX_TRIES     (MT)
  ) dut (
    .in_clock          (in_clock),
    .in_reset          (in_reset),
    .in_seed           (in_seed),
    .in_cfg_write      (in_cfg_write),
    .in_cfg_variable   (in_cfg_variable),
    .in_cfg_slot       (in_cfg_slot),
    .in_cfg_start      (in_cfg_start),
    .in_cfg_end        (in_cfg_end),
    .in_cfg_size_write (in_cfg_size_write),
    .in_cfg_size       (in_cfg_size),
    .in_request        (in_request),
    .in_variable_index (in_variable_index),
    .out_ready         (out_ready),
    .out_valid         (out_valid),
    .out_start         (out_start),
    .out_end           (out_end),
    .out_equal         (out_equal),
    .out_slot          (out_slot),
    .out_fallback      (out_fallback),
    .out_error         (out_error)
  );

  int n_total = 0;
  int n_bad   = 0;

  // Reference model state: random source, shadow table, shadow sizes
  logic [15:0] m_lfsr;
  int m_size  [NV];
  int m_start [NV][MV];
  int m_end   [NV][MV];
  int g_slot;
  bit g_fb;

  typedef struct {
    int v;
    int size_wr;
    int exp_size;
    bit exp_err;
  } vec_t;
  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [15:0] m_step(input logic [15:0] s);
    logic [15:0] n;
    n = s >> 1;
    if (s[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  // One full draw: each attempt consumes one LFSR value
  task automatic model_draw(input int size, output int slot, output bit fb, output int ncyc);
    int c;
    slot = 0;
    fb   = 1'b0;
    ncyc = 0;
    if (size == 0) begin
      m_lfsr = m_step(m_lfsr);
      ncyc   = 1;
      return;
    end
    for (int t = 0; t < MT; t++) begin
      c      = int'(m_lfsr) % (1 << SIW);
      m_lfsr = m_step(m_lfsr);
      ncyc   = t + 1;
      if (c < size) begin
        slot = c;
        return;
      end
      if (t == MT - 1) begin
        slot = c % size;
        fb   = 1'b1;
      end
    end
  endtask

  task automatic clear_shadow();
    for (int v = 0; v < NV; v++) begin
      m_size[v] = 0;
      for (int s = 0; s < MV; s++) begin
        m_start[v][s] = 0;
        m_end[v][s]   = 0;
      end
    end
  endtask

  task automatic do_reset(input logic [15:0] seed);
    in_seed  = seed;
    in_reset = 1'b1;
    repeat (2) @(posedge in_clock);
    #1;
    in_reset = 1'b0;
    m_lfsr = (seed == 16'h0000) ? 16'hACE1 : seed;
    clear_shadow();
  endtask

  task automatic cfg(input bit wr, input int v, input int s, input int st, input int en,
                     input bit szwr, input int sz);
    in_cfg_write      = wr;
    in_cfg_size_write = szwr;
    in_cfg_variable   = VIW'(v);
    in_cfg_slot       = SIW'(s);
    in_cfg_start      = VW'(st);
    in_cfg_end        = VW'(en);
    in_cfg_size       = (SIW + 1)'(sz);
    @(posedge in_clock);
    #1;
    in_cfg_write      = 1'b0;
    in_cfg_size_write = 1'b0;
    if (wr) begin
      m_start[v][s] = st;
      m_end[v][s]   = en;
    end
    if (szwr) m_size[v] = (sz > MV) ? MV : sz;
  endtask

  // Request a draw; optionally drive a config write during the first DRAW cycle
  task automatic do_req(input int v, input bit inject, input int iv, input int ist, input int ien);
    int es, ec, lat, sz, xs, xe;
    bit efb, eerr;
    chk("ready_before_req", out_ready, 1);
    sz   = m_size[v];
    eerr = (sz == 0);
    model_draw(sz, es, efb, ec);
    xs = eerr ? 0 : m_start[v][es];
    xe = eerr ? 0 : m_end[v][es];
    in_request        = 1'b1;
    in_variable_index = VIW'(v);
    @(posedge in_clock);
    #1;
    in_request = 1'b0;
    if (inject) begin
      in_cfg_write      = 1'b1;
      in_cfg_size_write = 1'b1;
      in_cfg_variable   = VIW'(iv);
      in_cfg_slot       = '0;
      in_cfg_start      = VW'(ist);
      in_cfg_end        = VW'(ien);
      in_cfg_size       = '0;
    end
    lat = 0;
    do begin
      @(posedge in_clock);
      #1;
      lat++;
      if (inject && lat == 1) begin
        in_cfg_write      = 1'b0;
        in_cfg_size_write = 1'b0;
      end
    end while (!out_valid && lat < 40);
    chk("valid_latency", lat, eerr ? 2 : ec + 2);
    chk("out_valid", out_valid, 1);
    chk("out_error", out_error, eerr);
    chk("out_fallback", out_fallback, efb);
    chk("out_slot", out_slot, es);
    chk("out_start", out_start, xs);
    chk("out_end", out_end, xe);
    chk("out_equal", out_equal, (xs == xe));
    g_slot = int'(out_slot);
    g_fb   = out_fallback;
    @(posedge in_clock);
    #1;
    chk("valid_one_cycle", out_valid, 0);
    chk("ready_after_valid", out_ready, 1);
  endtask

  task automatic program_all();
    cfg(1, 2, 0, 3, 3, 0, 0);
    cfg(1, 2, 1, 10, 20, 0, 0);
    cfg(1, 2, 2, 30, 40, 0, 0);
    cfg(1, 2, 3, 50, 60, 1, 4);
    for (int v = 0; v < NV; v++) begin
      if (v != 2) begin
        for (int s = 0; s < MV; s++) cfg(1, v, s, 16 * v + 4 * s, 16 * v + 5 * s, 0, 0);
      end
    end
  endtask

  initial begin
    #950000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int es, ec, dut_fb, mdl_fb, nf;
    bit efb;
    int hist [MV];
    in_reset = 1'b1; in_seed = 16'h0; in_cfg_write = 1'b0; in_cfg_variable = '0;
    in_cfg_slot = '0; in_cfg_start = '0; in_cfg_end = '0; in_cfg_size_write = 1'b0;
    in_cfg_size = '0; in_request = 1'b0; in_variable_index = '0;
    @(posedge in_clock);
    #1;
    do_reset(16'hBEEF);

    chk("rst_ready", out_ready, 1);
    chk("rst_valid", out_valid, 0);
    chk("rst_start", out_start, 0);
    chk("rst_end", out_end, 0);
    chk("rst_equal", out_equal, 0);
    chk("rst_slot", out_slot, 0);
    chk("rst_fallback", out_fallback, 0);
    chk("rst_error", out_error, 0);

    // Programmed variable 2, size 4, plus an empty variable 1
    program_all();
    for (int i = 0; i < 20; i++) do_req(2, 0, 0, 0, 0);
    do_req(1, 0, 0, 0, 0);

    // Size writes including saturation
    tbl[0] = '{v:2, size_wr:4, exp_size:4, exp_err:1'b0};
    tbl[1] = '{v:1, size_wr:0, exp_size:0, exp_err:1'b1};
    tbl[2] = '{v:3, size_wr:1, exp_size:1, exp_err:1'b0};
    tbl[3] = '{v:0, size_wr:3, exp_size:3, exp_err:1'b0};
    tbl[4] = '{v:0, size_wr:7, exp_size:4, exp_err:1'b0};
    tbl[5] = '{v:3, size_wr:5, exp_size:4, exp_err:1'b0};
    tbl[6] = '{v:1, size_wr:2, exp_size:2, exp_err:1'b0};
    tbl[7] = '{v:2, size_wr:6, exp_size:4, exp_err:1'b0};
    for (int i = 0; i < 8; i++) begin
      cfg(0, tbl[i].v, 0, 0, 0, 1, tbl[i].size_wr);
      m_size[tbl[i].v] = tbl[i].exp_size;
      for (int r = 0; r < 3; r++) begin
        do_req(tbl[i].v, 0, 0, 0, 0);
        chk("tbl_error", out_error, tbl[i].exp_err);
      end
    end

    // Config during DRAW is ignored, the same write in IDLE applies
    cfg(1, 3, 0, 5, 6, 1, 1);
    do_req(0, 1, 3, 7, 8);
    do_req(3, 0, 0, 0, 0);
    chk("draw_write_ignored_start", out_start, 5);
    cfg(1, 3, 0, 7, 8, 1, 1);
    do_req(3, 0, 0, 0, 0);
    chk("idle_write_applied_start", out_start, 7);
    cfg(1, 3, 1, 1, 2, 1, 0);
    do_req(3, 0, 0, 0, 0);
    chk("idle_size0_error", out_error, 1);

    // Randomised configuration and requests
    do_reset(16'($urandom));
    program_all();
    for (int i = 0; i < 400; i++) begin
      case ($urandom_range(0, 4))
        0: cfg(1, $urandom_range(0, NV - 1), $urandom_range(0, MV - 1),
               $urandom_range(0, 255), $urandom_range(0, 255), 0, 0);
        1: cfg(0, $urandom_range(0, NV - 1), 0, 0, 0, 1, $urandom_range(0, 7));
        2: cfg(1, $urandom_range(0, NV - 1), $urandom_range(0, MV - 1),
               $urandom_range(0, 255), $urandom_range(0, 255), 1, $urandom_range(0, 7));
        default: do_req($urandom_range(0, NV - 1), 0, 0, 0, 0);
      endcase
    end

    // Zero seed, size 1: always slot 0, fallback after MAX_TRIES rejections
    do_reset(16'h0000);
    cfg(1, 0, 0, 9, 9, 1, 1);
    dut_fb = 0;
    mdl_fb = 0;
    for (int i = 0; i < 200; i++) begin
      logic [15:0] save;
      save = m_lfsr;
      model_draw(1, es, efb, ec);
      m_lfsr = save;
      if (efb) mdl_fb++;
      do_req(0, 0, 0, 0, 0);
      chk("size1_slot0", out_slot, 0);
      if (g_fb) dut_fb++;
    end
    chk("size1_fallback_count", dut_fb, mdl_fb);

    // Histogram over size 3
    do_reset(16'h1234);
    program_all();
    cfg(0, 0, 0, 0, 0, 1, 3);
    for (int s = 0; s < MV; s++) hist[s] = 0;
    nf = 0;
    for (int i = 0; i < 10000; i++) begin
      do_req(0, 0, 0, 0, 0);
      if (!g_fb) begin
        hist[g_slot]++;
        nf++;
      end
    end
    chk("hist_slot3_never", hist[3], 0);
    for (int s = 0; s < 3; s++) begin
      n_total++;
      if ((hist[s] * 3 - nf) * 100 > nf * 5 || (nf - hist[s] * 3) * 100 > nf * 5) begin
        n_bad++;
        $display("FAIL hist_slot%0d: got %0d of %0d expected within 5pct of %0d", s, hist[s], nf, nf / 3);
      end
    end

    // Reset while in LOOKUP aborts the draw and clears the table
    do_reset(16'h4321);
    program_all();
    model_draw(m_size[2], es, efb, ec);
    in_request = 1'b1;
    in_variable_index = 2'd2;
    @(posedge in_clock);
    #1;
    in_request = 1'b0;
    repeat (ec) begin
      @(posedge in_clock);
      #1;
    end
    in_reset = 1'b1;
    @(posedge in_clock);
    #1;
    in_reset = 1'b0;
    chk("abort_no_valid", out_valid, 0);
    chk("abort_ready", out_ready, 1);
    m_lfsr = in_seed;
    clear_shadow();
    @(posedge in_clock);
    #1;
    chk("abort_no_valid_later", out_valid, 0);
    do_req(2, 0, 0, 0, 0);
    chk("abort_old_var_error", out_error, 1);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
